// File: rtl/qos_pkg.sv
// Shared QoS definitions for the VC read/write paths:
// the pop-arbiter FSM encoding and the default VC1 weight.
package qos_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PAUSE  = 2'd3
    } arb_state_t;

    localparam int WEIGHT_DEFAULT = 3;

endpackage

// File: rtl/vc_wrr_grant.sv
// Strict-priority VC1 grant with a weighted anti-starvation slot for VC0.
// Holds the starve counter that limits consecutive VC1 pops while VC0 waits.
module vc_wrr_grant
    import qos_pkg::*;
#(
    parameter int WEIGHT = WEIGHT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic elig0,
    input  logic elig1,
    input  logic en,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [3:0] W_LIMIT = 4'(WEIGHT);

    logic [3:0] r_starve;
    logic       w_pick1;

    // VC1 wins unless VC0 is waiting and has already been passed over WEIGHT times.
    assign w_pick1 = elig1 && ((r_starve < W_LIMIT) || !elig0);
    assign gnt1    = en && w_pick1;
    assign gnt0    = en && elig0 && !w_pick1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (!elig0 || gnt0) begin
            r_starve <= '0;
        end else if (gnt1 && (r_starve < W_LIMIT)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Read-side controller for two VC FIFOs: pops by weighted priority and forwards
// the popped word, registered, to one downstream FIFO, stalling on almost-full.
module vc_pop_arbiter
    import qos_pkg::*;
#(
    parameter int BW     = 6,
    parameter int WEIGHT = WEIGHT_DEFAULT,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vc0_empty,
    input  logic          vc1_empty,
    input  logic [BW-1:0] vc0_data,
    input  logic [BW-1:0] vc1_data,
    input  logic          dst_almost_full,
    input  logic          dst_full,
    output logic          vc0_rd,
    output logic          vc1_rd,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          active_vc,
    output logic [CW-1:0] vc0_cnt,
    output logic [CW-1:0] vc1_cnt,
    output logic          error_output
);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic          w_issue_en;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_elig0;
    logic          w_elig1;

    logic [BW-1:0] r_data;
    logic          r_valid;
    logic          r_vc;
    logic [CW-1:0] r_vc0_cnt;
    logic [CW-1:0] r_vc1_cnt;
    logic          r_error;

    assign w_elig0 = !vc0_empty;
    assign w_elig1 = !vc1_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT:   w_state_next = ST_IDLE;
            ST_IDLE:   if (w_elig0 || w_elig1) w_state_next = ST_ACTIVE;
            ST_ACTIVE: begin
                if (dst_almost_full)            w_state_next = ST_PAUSE;
                else if (!w_elig0 && !w_elig1)  w_state_next = ST_IDLE;
            end
            ST_PAUSE:  if (!dst_almost_full) w_state_next = ST_ACTIVE;
            default:   w_state_next = ST_INIT;
        endcase
    end

    // Reset also gates issue so no upstream word is popped and then discarded.
    always_comb begin
        w_issue_en = 1'b0;
        if ((r_state == ST_ACTIVE) && !dst_almost_full && !reset) begin
            w_issue_en = 1'b1;
        end
    end

    vc_wrr_grant #(
        .WEIGHT (WEIGHT)
    ) u_grant (
        .clk   (clk),
        .reset (reset),
        .elig0 (w_elig0),
        .elig1 (w_elig1),
        .en    (w_issue_en),
        .gnt0  (w_gnt0),
        .gnt1  (w_gnt1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_vc      <= 1'b0;
            r_vc0_cnt <= '0;
            r_vc1_cnt <= '0;
            r_error   <= 1'b0;
        end else begin
            r_valid <= w_gnt0 || w_gnt1;
            if (w_gnt1) begin
                r_data    <= vc1_data;
                r_vc      <= 1'b1;
                r_vc1_cnt <= r_vc1_cnt + CW'(1);
            end else if (w_gnt0) begin
                r_data    <= vc0_data;
                r_vc      <= 1'b0;
                r_vc0_cnt <= r_vc0_cnt + CW'(1);
            end
            if (r_valid && dst_full) begin
                r_error <= 1'b1;
            end
        end
    end

    assign vc0_rd       = w_gnt0;
    assign vc1_rd       = w_gnt1;
    assign data_out     = r_data;
    assign valid_out    = r_valid;
    assign active_vc    = r_vc;
    assign vc0_cnt      = r_vc0_cnt;
    assign vc1_cnt      = r_vc1_cnt;
    assign error_output = r_error;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: queue-modelled VC FIFOs, a behavioural reference
// checked every cycle, directed scenarios with literal pins, then random traffic.
module tb_vc_pop_arbiter;

    localparam int BW     = 6;
    localparam int WEIGHT = 3;
    localparam int CW     = 8;

    localparam int P_INIT = 0, P_IDLE = 1, P_ACT = 2, P_PAUSE = 3;

    logic          clk;
    logic          reset;
    logic          vc0_empty, vc1_empty;
    logic [BW-1:0] vc0_data, vc1_data;
    logic          dst_almost_full, dst_full;
    logic          vc0_rd, vc1_rd;
    logic [BW-1:0] data_out;
    logic          valid_out, active_vc;
    logic [CW-1:0] vc0_cnt, vc1_cnt;
    logic          error_output;

    vc_pop_arbiter #(.BW(BW), .WEIGHT(WEIGHT), .CW(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .vc0_empty       (vc0_empty),
        .vc1_empty       (vc1_empty),
        .vc0_data        (vc0_data),
        .vc1_data        (vc1_data),
        .dst_almost_full (dst_almost_full),
        .dst_full        (dst_full),
        .vc0_rd          (vc0_rd),
        .vc1_rd          (vc1_rd),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .active_vc       (active_vc),
        .vc0_cnt         (vc0_cnt),
        .vc1_cnt         (vc1_cnt),
        .error_output    (error_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // upstream FIFOs
    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    // logs of observed DUT activity
    int            rd_log[$];
    logic [BW-1:0] out_log[$];

    // reference model
    int            m_phase;
    int            m_streak;
    bit            m_valid, m_vc, m_err;
    logic [BW-1:0] m_data;
    logic [CW-1:0] m_cnt0, m_cnt1;

    bit cur_rst, cur_af, cur_full;
    bit el0, el1, e_rd0, e_rd1, a_rd0, a_rd1;

    task automatic model_reset();
        m_phase  = P_INIT;
        m_streak = 0;
        m_valid  = 0;
        m_vc     = 0;
        m_err    = 0;
        m_data   = '0;
        m_cnt0   = '0;
        m_cnt1   = '0;
    endtask

    task automatic check();
        bit allow;
        el0   = (q0.size() != 0);
        el1   = (q1.size() != 0);
        allow = !cur_rst && (m_phase == P_ACT) && !cur_af;
        e_rd1 = allow && el1 && ((m_streak < WEIGHT) || !el0);
        e_rd0 = allow && el0 && !e_rd1;
        a_rd0 = vc0_rd;
        a_rd1 = vc1_rd;
        n_tests++;
        if ({a_rd0, a_rd1} !== {e_rd0, e_rd1}) begin
            n_fail++;
            $display("FAIL rd t=%0t: got rd0=%b rd1=%b expected rd0=%b rd1=%b", $time, a_rd0, a_rd1, e_rd0, e_rd1);
        end
        n_tests++;
        if (valid_out !== m_valid || active_vc !== m_vc || data_out !== m_data ||
            vc0_cnt !== m_cnt0 || vc1_cnt !== m_cnt1 || error_output !== m_err) begin
            n_fail++;
            $display("FAIL outs t=%0t: got v=%b vc=%b d=%h c0=%0d c1=%0d err=%b expected v=%b vc=%b d=%h c0=%0d c1=%0d err=%b",
                     $time, valid_out, active_vc, data_out, vc0_cnt, vc1_cnt, error_output,
                     m_valid, m_vc, m_data, m_cnt0, m_cnt1, m_err);
        end
        if (a_rd0 || a_rd1) rd_log.push_back(a_rd1 ? 1 : 0);
        if (valid_out === 1'b1) out_log.push_back(data_out);
    endtask

    task automatic model_step();
        if (cur_rst) begin
            model_reset();
        end else begin
            if (m_valid && cur_full) m_err = 1;
            m_valid = e_rd0 || e_rd1;
            if (e_rd1) begin
                m_data = q1[0]; m_vc = 1; m_cnt1 = m_cnt1 + 1'b1;
            end else if (e_rd0) begin
                m_data = q0[0]; m_vc = 0; m_cnt0 = m_cnt0 + 1'b1;
            end
            if (!el0 || e_rd0)                    m_streak = 0;
            else if (e_rd1 && m_streak < WEIGHT)  m_streak = m_streak + 1;
            case (m_phase)
                P_INIT:  m_phase = P_IDLE;
                P_IDLE:  if (el0 || el1) m_phase = P_ACT;
                P_ACT:   if (cur_af) m_phase = P_PAUSE;
                         else if (!el0 && !el1) m_phase = P_IDLE;
                default: if (!cur_af) m_phase = P_ACT;
            endcase
        end
        // the FIFOs pop on whatever the DUT actually strobed
        if (a_rd0 && q0.size() != 0) void'(q0.pop_front());
        if (a_rd1 && q1.size() != 0) void'(q1.pop_front());
    endtask

    task automatic tick(input bit rst, input bit af, input bit full);
        @(negedge clk);
        cur_rst = rst; cur_af = af; cur_full = full;
        reset = rst; dst_almost_full = af; dst_full = full;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = (q0.size() != 0) ? q0[0] : '0;
        vc1_data  = (q1.size() != 0) ? q1[0] : '0;
        #1;
        check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pin(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        tick(1, 0, 0);
        tick(1, 0, 0);
        rd_log.delete(); out_log.delete();
    endtask

    initial begin
        int wmix[12];
        logic [BW-1:0] pushed[$];
        bit seen;
        reset = 1; vc0_empty = 1; vc1_empty = 1; vc0_data = '0; vc1_data = '0;
        dst_almost_full = 0; dst_full = 0;
        model_reset();

        // reset then idle
        do_reset();
        pin("reset_state_init", int'(dut.r_state), 0);
        pin("reset_outs_zero", int'({valid_out, data_out, active_vc, vc0_cnt, vc1_cnt, error_output}), 0);
        tick(0, 0, 0);
        pin("state_idle", int'(dut.r_state), 1);
        for (int i = 0; i < 20; i++) tick(0, 0, 0);
        pin("idle_no_rd", rd_log.size(), 0);

        // VC1 only
        do_reset();
        for (int i = 1; i <= 5; i++) q1.push_back(BW'(i));
        for (int i = 0; i < 12; i++) tick(0, 0, 0);
        pin("vc1_only_words", out_log.size(), 5);
        for (int i = 0; i < 5 && i < out_log.size(); i++) pin("vc1_only_data", int'(out_log[i]), i + 1);
        pin("vc1_only_cnt1", int'(vc1_cnt), 5);
        pin("vc1_only_cnt0", int'(vc0_cnt), 0);

        // weighted mix
        do_reset();
        wmix = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) q1.push_back(BW'(32 + i));
        for (int i = 0; i < 4; i++) q0.push_back(BW'(16 + i));
        for (int i = 0; i < 25; i++) tick(0, 0, 0);
        pin("wmix_len", rd_log.size(), 12);
        for (int i = 0; i < 12 && i < rd_log.size(); i++) pin("wmix_grant", rd_log[i], wmix[i]);
        pin("wmix_cnt0", int'(vc0_cnt), 4);
        pin("wmix_cnt1", int'(vc1_cnt), 8);

        // backpressure mid-stream
        do_reset();
        pushed.delete();
        for (int i = 0; i < 12; i++) begin
            q1.push_back(BW'(i * 5 + 3));
            pushed.push_back(BW'(i * 5 + 3));
        end
        for (int c = 0; c < 30; c++) tick(0, (c >= 6 && c < 10), 0);
        pin("bp_count", out_log.size(), 12);
        for (int i = 0; i < 12 && i < out_log.size(); i++) pin("bp_data", int'(out_log[i]), int'(pushed[i]));

        // overflow error
        do_reset();
        for (int i = 0; i < 3; i++) q0.push_back(BW'(i + 7));
        for (int i = 0; i < 8; i++) tick(0, 0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 0);
        pin("err_sticky", int'(error_output), 1);
        tick(1, 0, 0);
        pin("err_cleared", int'(error_output), 0);

        // counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) q0.push_back(BW'(i));
        for (int i = 0; i < 262; i++) tick(0, 0, 0);
        pin("wrap_words", out_log.size(), 256);
        pin("wrap_cnt0", int'(vc0_cnt), 0);

        // reset during a stream
        do_reset();
        for (int i = 0; i < 10; i++) q1.push_back(BW'(i + 40));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(0, 0, 0);
            if (rd_log.size() != 0) seen = 1;
        end
        pin("midrst_saw_pop", int'(seen), 1);
        tick(1, 0, 0);
        pin("midrst_valid", int'(valid_out), 0);
        pin("midrst_state", int'(dut.r_state), 0);
        tick(0, 0, 0);

        // random traffic against the model
        q0.delete(); q1.delete();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 35 && q0.size() < 16) q0.push_back(BW'($urandom));
            if ($urandom_range(0, 99) < 40 && q1.size() < 16) q1.push_back(BW'($urandom));
            tick($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_pop_arbiter.md
# vc_pop_arbiter

Read-side controller for a pair of virtual-channel FIFOs (VC0, VC1) in the TC/VC QoS path. It issues pops to the two upstream FIFOs and forwards the popped words, registered, to a single downstream FIFO. Arbitration gives VC1 strict priority with a weighted anti-starvation slot for VC0. Issue stalls while the downstream FIFO reports almost-full.

## Interface
Parameters:
- BW, 6, data width of every VC word.
- WEIGHT, 3, maximum consecutive VC1 pops while VC0 is non-empty; range 1..15.
- CW, 8, width of the per-VC pop counters.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- vc0_empty, vc1_empty  in  1 each  empty flags from the VC FIFOs.
- vc0_data, vc1_data  in  BW each  FIFO read data; valid combinationally in the same cycle as the matching rd.
- dst_almost_full  in  1  downstream almost-full flag (threshold programmed upstream).
- dst_full  in  1  downstream full flag.
- vc0_rd, vc1_rd  out  1 each  pop strobes; combinational; never both high.
- data_out  out  BW  registered forwarded word.
- valid_out  out  1  registered write strobe to the downstream FIFO.
- active_vc  out  1  VC of the word on data_out (0 or 1); registered.
- vc0_cnt, vc1_cnt  out  CW each  successful-pop counters; wrap modulo 2^CW.
- error_output  out  1  sticky; set when valid_out is high while dst_full is high.

## Operation
- FSM states:
  - INIT: first cycle after reset; no pops.
  - IDLE
  - ACTIVE
  - PAUSE
- Transitions:
  - INIT→IDLE unconditionally.
  - IDLE→ACTIVE when either empty flag is low.
  - ACTIVE→PAUSE when dst_almost_full=1. Checked first.
  - ACTIVE→IDLE when both empty flags are high.
  - PAUSE→ACTIVE when dst_almost_full=0.
- Eligibility: elig0=!vc0_empty, elig1=!vc1_empty. A pop is allowed only in ACTIVE with dst_almost_full=0.
- Grant:
  - VC1 if elig1 and (starve<WEIGHT or !elig0).
  - Otherwise VC0 if elig0.
  - Otherwise none.
- starve counter (4 bits):
  - +1 on a VC1 pop while elig0.
  - Cleared on a VC0 pop, or in any cycle with !elig0.
  - Saturates at WEIGHT.
- On a pop: data_out and active_vc capture the selected word and VC, valid_out=1, and the matching counter increments. With no pop, valid_out=0 and data_out/active_vc hold their values.
- error_output is set once and cleared only by reset.

## Timing
- Reset values:
  - State INIT.
  - All outputs 0: vc0_rd, vc1_rd, data_out, valid_out, active_vc, vc0_cnt, vc1_cnt, error_output.
  - starve=0.
- rd is asserted in cycle N. data_out/valid_out appear in cycle N+1, i.e. one cycle of latency.
- dst_almost_full gates rd in the same cycle. The word already registered still writes in the next cycle. The downstream almost-full threshold must therefore leave at least 1 free entry.
- PAUSE→ACTIVE costs one bubble cycle: the first pop occurs in the first cycle back in ACTIVE.
- If a FIFO goes empty in the cycle of a grant decision, the flag is honoured that cycle and no pop is issued to an empty FIFO.
- reset asserted mid-transfer: the next edge forces INIT, and all outputs, including a pending valid_out, drop to 0. The in-flight word is discarded.
- Counters wrap: 2^CW−1 + 1 → 0, with no flag.

## Structure
- Shared package (qos_pkg): FSM state encoding (INIT=2'd0, IDLE=2'd1, ACTIVE=2'd2, PAUSE=2'd3) and the WEIGHT default. The same package is used by the write-side VC classifier.
- One natural sub-module, vc_wrr_grant: combinational grant plus the starve register, with inputs elig0, elig1, en and outputs gnt0, gnt1.
- Everything else (FSM, output register, counters) stays in the top.

## Test plan
- Reset then idle: reset high for 2 cycles, both FIFOs empty → all outputs 0; state INIT then IDLE; no rd pulses for 20 cycles.
- VC1 only: VC1 preloaded with 0x01..0x05, VC0 empty → vc1_rd for 5 cycles; data_out 0x01..0x05 one cycle later with active_vc=1; vc1_cnt=5.
- Weighted mix: VC1 holds 8 words, VC0 holds 4, WEIGHT=3 → grant sequence 1,1,1,0,1,1,1,0,1,1,0,0; vc0_cnt=4, vc1_cnt=8.
- Backpressure: dst_almost_full raised during a stream → rd low that same cycle; one trailing valid_out; resumes one cycle after the flag drops; no word lost or duplicated.
- Overflow error: force dst_full=1 while valid_out=1 → error_output=1, still 1 after 10 idle cycles, cleared by reset.
- Reset mid-stream plus wrap: run 256 VC0 pops with CW=8 → vc0_cnt=0; then assert reset during a pop → the next cycle has valid_out=0 and state INIT.
